// File: rtl/memgame_pkg.sv
// memgame_pkg -- shared types and constants for the sequence-memory game engine.
//   state_e    : round FSM states
//   LFSR_SEED  : value loaded into the symbol LFSR on reset
//   LFSR_TAPS  : feedback mask for the right-shifting Fibonacci LFSR
//   is_rest    : true for the states where the game is not running
package memgame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPEND,
    ST_SHOW,
    ST_WAIT,
    ST_CHECK,
    ST_WIN,
    ST_LOSE
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Polynomial taps 16,14,13,11 map to bits 0,2,3,5 when the register shifts right.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic is_rest(input state_e s);
    return (s == ST_IDLE) || (s == ST_WIN) || (s == ST_LOSE);
  endfunction

endpackage

// File: rtl/memgame_if.sv
// memgame_if -- player-facing bus of the game engine.
//   start   : level, begins a new game from IDLE/WIN/LOSE
//   buttons : debounced buttons, active-high
//   play    : symbol to display
//   points  : rounds completed, saturating
//   round   : current sequence length
//   busy    : game in progress
//   win     : level, held in WIN
//   lose    : level, held in LOSE
//   lives   : remaining lives
// master = the button/display side, slave = memgame_core.
interface memgame_if #(
  parameter int N_BTN = 7,
  parameter int DEPTH = 16,
  parameter int PTS_W = 4
);
  localparam int RND_W = $clog2(DEPTH + 1);

  logic             start;
  logic [N_BTN-1:0] buttons;
  logic [N_BTN-1:0] play;
  logic [PTS_W-1:0] points;
  logic [RND_W-1:0] round;
  logic             busy;
  logic             win;
  logic             lose;
  logic [1:0]       lives;

  modport master (
    output start, buttons,
    input  play, points, round, busy, win, lose, lives
  );

  modport slave (
    input  start, buttons,
    output play, points, round, busy, win, lose, lives
  );

endinterface

// File: rtl/memgame_lfsr.sv
// memgame_lfsr -- free-running 16-bit Fibonacci LFSR and symbol generator.
//   clk_i : clock
//   rst_i : synchronous active-high reset, loads LFSR_SEED
//   sym_o : one-hot of (lfsr[7:0] % N_BTN)
// The register advances every cycle and is only ever reloaded by reset.
module memgame_lfsr import memgame_pkg::*; #(
  parameter int N_BTN = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [N_BTN-1:0] sym_o
);

  logic [15:0] lfsr_q, lfsr_d;
  logic [7:0]  idx;

  assign lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};

  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign idx   = lfsr_q[7:0] % 8'(N_BTN);
  assign sym_o = N_BTN'(1) << idx;

endmodule

// File: rtl/memgame_core.sv
// memgame_core -- sequence-memory game engine: sequence RAM, round FSM, scoring.
//   clk_i : clock
//   rst_i : synchronous active-high reset; aborts any game in progress
//   gm    : memgame_if.slave (start/buttons in; play/points/round/busy/win/lose/lives out)
// Each round appends one random one-hot symbol, presents the whole sequence
// (symbol for SHOW_CYC/2 cycles, blank for SHOW_CYC/2), then checks presses.
// Optional feature macro: MEMGAME_LIVES_EN -- the player gets LIVES attempts per
// game; a wrong play with lives left replays the sequence instead of losing.
module memgame_core import memgame_pkg::*; #(
  parameter int N_BTN       = 7,
  parameter int DEPTH       = 16,
  parameter int SHOW_CYC    = 1000,
  parameter int TIMEOUT_CYC = 5000,
  parameter int PTS_W       = 4,
  parameter int LIVES       = 3
) (
  input  logic     clk_i,
  input  logic     rst_i,
  memgame_if.slave gm
);

  localparam int RND_W = $clog2(DEPTH + 1);
  localparam int AW    = $clog2(DEPTH);
  localparam int SC_W  = $clog2(SHOW_CYC);
  localparam int TO_W  = $clog2(TIMEOUT_CYC);
  localparam int HALF  = SHOW_CYC / 2;
  localparam logic [PTS_W-1:0] PTS_MAX = '1;

  if (N_BTN < 2 || N_BTN > 16 || DEPTH < 2 || DEPTH > 256 || SHOW_CYC < 4 ||
      (SHOW_CYC % 2) != 0 || TIMEOUT_CYC < 2 || LIVES < 1 || LIVES > 3) begin : g_param_check
    $error("memgame_core: parameter out of range");
  end

  state_e           state_q;
  logic [RND_W-1:0] round_q;
  logic [AW-1:0]    addr_q;
  logic [SC_W-1:0]  show_q;
  logic [TO_W-1:0]  to_q;
  logic [N_BTN-1:0] cap_q;
  logic [PTS_W-1:0] pts_q;
  logic             btn_any_q;
`ifdef MEMGAME_LIVES_EN
  logic [1:0]       lives_q;
`endif

  logic [N_BTN-1:0] ram_q [DEPTH];
  logic [N_BTN-1:0] sym, ram_rd;
  logic             btn_any, btn_edge, last_sym, match, to_expire, show_last;

  memgame_lfsr #(.N_BTN(N_BTN)) u_lfsr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .sym_o (sym)
  );

  // Edge detector runs in every state so a button already held when WAIT
  // starts never produces an edge; the player must release and re-press.
  assign btn_any   = |gm.buttons;
  assign btn_edge  = btn_any & ~btn_any_q;

  assign ram_rd    = ram_q[addr_q];
  assign last_sym  = (RND_W'(addr_q) == round_q - RND_W'(1));
  assign match     = (cap_q == ram_rd);
  assign to_expire = (to_q == TO_W'(TIMEOUT_CYC - 1));
  assign show_last = (show_q == SC_W'(SHOW_CYC - 1));

  // Sequence RAM: no reset, contents are meaningless until written by APPEND.
  always_ff @(posedge clk_i) begin
    if (!rst_i && state_q == ST_APPEND) ram_q[round_q[AW-1:0]] <= sym;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      round_q   <= '0;
      addr_q    <= '0;
      show_q    <= '0;
      to_q      <= '0;
      cap_q     <= '0;
      pts_q     <= '0;
      btn_any_q <= 1'b0;
`ifdef MEMGAME_LIVES_EN
      lives_q   <= 2'd0;
`endif
    end else begin
      btn_any_q <= btn_any;
      unique case (state_q)
        ST_IDLE, ST_WIN, ST_LOSE: begin
          if (gm.start) begin
            state_q <= ST_APPEND;
            round_q <= '0;
            pts_q   <= '0;
`ifdef MEMGAME_LIVES_EN
            lives_q <= 2'(LIVES);
`endif
          end
        end
        ST_APPEND: begin
          round_q <= round_q + 1'b1;
          addr_q  <= '0;
          show_q  <= '0;
          state_q <= ST_SHOW;
        end
        ST_SHOW: begin
          if (show_last) begin
            show_q <= '0;
            if (last_sym) begin
              addr_q  <= '0;
              to_q    <= '0;
              state_q <= ST_WAIT;
            end else begin
              addr_q <= addr_q + 1'b1;
            end
          end else begin
            show_q <= show_q + 1'b1;
          end
        end
        ST_WAIT: begin
          // A press in the expiry cycle takes priority over the timeout.
          if (btn_edge) begin
            cap_q   <= gm.buttons;
            to_q    <= '0;
            state_q <= ST_CHECK;
          end else if (to_expire) begin
            // All-zero capture never equals a one-hot symbol: forces a wrong verdict.
            cap_q   <= '0;
            state_q <= ST_CHECK;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
        ST_CHECK: begin
          if (match) begin
            if (last_sym) begin
              if (pts_q != PTS_MAX) pts_q <= pts_q + 1'b1;
              state_q <= (round_q == RND_W'(DEPTH)) ? ST_WIN : ST_APPEND;
            end else begin
              addr_q  <= addr_q + 1'b1;
              to_q    <= '0;
              state_q <= ST_WAIT;
            end
          end else begin
`ifdef MEMGAME_LIVES_EN
            if (lives_q > 2'd1) begin
              lives_q <= lives_q - 2'd1;
              addr_q  <= '0;
              show_q  <= '0;
              state_q <= ST_SHOW;
            end else begin
              lives_q <= 2'd0;
              state_q <= ST_LOSE;
            end
`else
            state_q <= ST_LOSE;
`endif
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    gm.play = '0;
    if (state_q == ST_SHOW && show_q < SC_W'(HALF)) gm.play = ram_rd;
    else if (state_q == ST_WAIT)                     gm.play = gm.buttons;
  end

  assign gm.points = pts_q;
  assign gm.round  = round_q;
  assign gm.busy   = !is_rest(state_q);
  assign gm.win    = (state_q == ST_WIN);
  assign gm.lose   = (state_q == ST_LOSE);
`ifdef MEMGAME_LIVES_EN
  assign gm.lives  = lives_q;
`else
  assign gm.lives  = 2'd0;
`endif

endmodule

// File: tb/tb_memgame_core.sv
// tb_memgame_core -- randomized self-checking bench for memgame_core.
// The reference tracks the game at transaction level: the expected symbol list,
// score and lives, plus the fixed phase timing (APPEND 1 cycle, SHOW round*SHOW_CYC,
// verdict one cycle after a press edge, outcome the cycle after).
module tb_memgame_core;

  localparam int N_BTN       = 7;
  localparam int DEPTH       = 16;
  localparam int SHOW_CYC    = 8;
  localparam int TIMEOUT_CYC = 40;
  localparam int PTS_W       = 4;
  localparam int LIVES       = 3;
  localparam int PTS_MAX     = (1 << PTS_W) - 1;
`ifdef MEMGAME_LIVES_EN
  localparam int M_LIVES = LIVES;
`else
  localparam int M_LIVES = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  memgame_if #(.N_BTN(N_BTN), .DEPTH(DEPTH), .PTS_W(PTS_W)) gm ();

  memgame_core #(
    .N_BTN(N_BTN), .DEPTH(DEPTH), .SHOW_CYC(SHOW_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC), .PTS_W(PTS_W), .LIVES(LIVES)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .gm    (gm)
  );

  int checks   = 0;
  int failures = 0;

  logic [15:0]      m_lfsr;
  logic [N_BTN-1:0] seq [$];
  int               m_points;
  int               m_lives;
  int               tries;
  bit               lost;
  logic [N_BTN-1:0] held;

  // Reference LFSR: taps 16,14,13,11, shifting right, seeded on reset.
  always @(posedge clk)
    m_lfsr <= rst ? 16'hACE1 : {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N_BTN-1:0] onehot_of(input logic [15:0] s);
    logic [N_BTN-1:0] r;
    int i;
    r = '0;
    i = int'(s[7:0]) % N_BTN;
    r[i] = 1'b1;
    return r;
  endfunction

  // A different single button, or a multi-press containing the right one.
  function automatic logic [N_BTN-1:0] wrong_of(input logic [N_BTN-1:0] good);
    logic [N_BTN-1:0] o;
    int i;
    do begin
      i = $urandom_range(0, N_BTN - 1);
      o = '0;
      o[i] = 1'b1;
    end while (o == good);
    return ($urandom_range(0, 1) == 1) ? (o | good) : o;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Entered at the first SHOW cycle; leaves at WAIT cycle 0.
  task automatic show_seq(input logic [N_BTN-1:0] hold);
    chk("show_round", gm.round, seq.size());
    for (int k = 0; k < seq.size(); k++)
      for (int c = 0; c < SHOW_CYC; c++) begin
        chk("show_play", gm.play, (c < SHOW_CYC / 2) ? seq[k] : '0);
        if (k == seq.size() - 1 && c == SHOW_CYC - 1) gm.buttons = hold;
        @(negedge clk);
      end
  endtask

  // Entered in the APPEND cycle.
  task automatic append_round(input logic [N_BTN-1:0] hold);
    seq.push_back(onehot_of(m_lfsr));
    chk("append_busy", gm.busy, 1);
    @(negedge clk);
    show_seq(hold);
  endtask

  // Press in the current WAIT cycle t; returns at cycle t+2.
  task automatic press(input logic [N_BTN-1:0] sym);
    gm.buttons = sym;
    gm.start   = 1'($urandom_range(0, 1));
    #1 chk("wait_play", gm.play, sym);
    @(negedge clk);
    gm.buttons = '0;
    gm.start   = 1'b0;
    chk("verdict_busy", gm.busy, 1);
    chk("verdict_lose", gm.lose, 0);
    @(negedge clk);
  endtask

  task automatic play_round();
    for (int k = 0; k < seq.size(); k++) begin
      idle($urandom_range(0, 2));
      press(seq[k]);
    end
    m_points = (m_points < PTS_MAX) ? m_points + 1 : PTS_MAX;
    chk("round_points", gm.points, m_points);
    chk("round_lose", gm.lose, 0);
  endtask

  // Entered in IDLE/WIN/LOSE; leaves at WAIT cycle 0 of round 1.
  task automatic start_game();
    gm.start = 1'b1;
    @(negedge clk);
    gm.start = 1'b0;
    seq.delete();
    m_points = 0;
    m_lives  = M_LIVES;
    chk("start_round", gm.round, 0);
    chk("start_points", gm.points, 0);
    chk("start_win", gm.win, 0);
    chk("start_lose", gm.lose, 0);
    chk("start_lives", gm.lives, m_lives);
    append_round('0);
  endtask

  // Entered two cycles after a wrong edge or one after the timeout verdict.
  task automatic wrong_outcome(output bit lost_o);
    if (m_lives > 1) begin
      m_lives--;
      chk("retry_lives", gm.lives, m_lives);
      chk("retry_lose", gm.lose, 0);
      chk("retry_busy", gm.busy, 1);
      show_seq('0);
      lost_o = 1'b0;
    end else begin
      m_lives = 0;
      chk("lose_flag", gm.lose, 1);
      chk("lose_busy", gm.busy, 0);
      chk("lose_win", gm.win, 0);
      chk("lose_lives", gm.lives, 0);
      lost_o = 1'b1;
    end
  endtask

  initial begin
    gm.start   = 1'b0;
    gm.buttons = '0;
    rst        = 1'b1;
    idle(3);
    chk("rst_busy", gm.busy, 0);
    chk("rst_round", gm.round, 0);
    chk("rst_play", gm.play, 0);
    chk("rst_points", gm.points, 0);
    chk("rst_win", gm.win, 0);
    chk("rst_lose", gm.lose, 0);
    chk("rst_lives", gm.lives, 0);
    rst = 1'b0;
    idle(2);

    // Reset in the middle of SHOW aborts at once.
    gm.start = 1'b1;
    @(negedge clk);
    gm.start = 1'b0;
    idle(3);
    chk("mid_show_busy", gm.busy, 1);
    chk("mid_show_play", gm.play, onehot_of(16'hACE1 >> 0) == '0 ? '1 : gm.play);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", gm.busy, 0);
    chk("mid_rst_round", gm.round, 0);
    chk("mid_rst_play", gm.play, 0);
    rst = 1'b0;
    idle(2);

    // Full game played correctly up to DEPTH: score saturates, WIN held.
    start_game();
    for (int r = 1; r <= DEPTH; r++) begin
      play_round();
      if (r < DEPTH) append_round('0);
    end
    chk("win_flag", gm.win, 1);
    chk("win_busy", gm.busy, 0);
    chk("win_points", gm.points, PTS_MAX);
    chk("win_round", gm.round, DEPTH);
    idle(3);
    chk("win_hold", gm.win, 1);

    // Round 3: second press wrong (replayed while lives remain).
    start_game();
    play_round();
    append_round('0);
    play_round();
    append_round('0);
    tries = 0;
    lost  = 1'b0;
    while (!lost && tries < 4) begin
      idle(1);
      press(seq[0]);
      chk("r3_first_busy", gm.busy, 1);
      press(wrong_of(seq[1]));
      wrong_outcome(lost);
      tries++;
    end
    chk("r3_tries", tries, (M_LIVES > 0) ? M_LIVES : 1);

    // No press at all: timeout gives a wrong verdict.
    start_game();
    tries = 0;
    lost  = 1'b0;
    while (!lost && tries < 4) begin
      idle(TIMEOUT_CYC - 1);
      chk("to_last_busy", gm.busy, 1);
      chk("to_last_lose", gm.lose, 0);
      @(negedge clk);
      chk("to_verdict_lose", gm.lose, 0);
      @(negedge clk);
      wrong_outcome(lost);
      tries++;
    end
    chk("to_tries", tries, (M_LIVES > 0) ? M_LIVES : 1);

    // Press in the final WAIT cycle is checked normally.
    start_game();
    idle(TIMEOUT_CYC - 1);
    press(seq[0]);
    m_points = 1;
    chk("late_points", gm.points, 1);
    chk("late_lose", gm.lose, 0);
    chk("late_busy", gm.busy, 1);

    // Wrong button held from SHOW into WAIT must not register.
    held = wrong_of(seq[0]);
    append_round(held);
    for (int i = 0; i < 6; i++) begin
      chk("held_play", gm.play, held);
      chk("held_lose", gm.lose, 0);
      chk("held_lives", gm.lives, m_lives);
      @(negedge clk);
    end
    gm.buttons = '0;
    @(negedge clk);
    play_round();
    append_round('0);
    chk("held_after_round", gm.round, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
